sram_serial_port: RTL and testbench
===================================

Name: sram_serial_port

Overview:
Parametrised serial-access SRAM port with a single command handshake.
- Write data arrives bit-serially and is assembled in an internal SIPO, then committed to the row array.
- Read data is returned both as a parallel word and bit-serially through an internal PISO.
- Supersedes the fixed-geometry SIPO-plus-array front end: adds configurable read latency, command flow control, out-of-range detection and serial readback.

Parameters:
COLS, 8, word width in bits (>=2)
ROWS, 16, number of rows; need not be a power of two
RD_LAT, 1, array read latency in cycles (1..4)
AW, $clog2(ROWS), address width (derived, not overridden)

Ports:
clk  input  1  clock; all logic on rising edge
arst_n  input  1  synchronous, active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  port idle, command may be accepted
cmd_we  input  1  1 = write, 0 = read; sampled at handshake
cmd_addr  input  AW  row address; sampled at handshake
serial_in  input  1  write data bit, MSB first
serial_in_valid  input  1  serial_in qualifier
data_valid  output  1  one-cycle pulse, data_out valid
data_out  output  COLS  read word; held until next read
serial_out  output  1  read data bit, MSB first
serial_out_valid  output  1  serial_out qualifier
addr_err  output  1  one-cycle pulse, address >= ROWS
busy  output  1  state != IDLE

Behaviour:
- Reset (arst_n low at an edge):
  - State -> IDLE.
  - cmd_ready=1 (after the reset edge). All other outputs, the shift registers and the bit counter = 0.
  - Array contents are not cleared.
  - Reset mid-operation aborts it: a partial write never reaches the array.
- Handshake: accept on an edge with cmd_valid && cmd_ready. cmd_ready = (state==IDLE). No queuing.
- States: IDLE, SHIFT_IN, WRITE, READ, SHIFT_OUT.
- IDLE:
  - Accept with cmd_we=1 -> SHIFT_IN; latch addr; clear bit counter.
  - Accept with cmd_we=0 -> READ; load latency counter = RD_LAT.
- SHIFT_IN:
  - Each edge with serial_in_valid: sreg <= {sreg[COLS-2:0], serial_in}; counter++.
  - Edges without serial_in_valid hold state (gaps allowed, no timeout).
  - When the COLS-th bit is sampled -> WRITE.
- WRITE:
  - One cycle: mem[addr] <= sreg -> IDLE.
  - If addr >= ROWS: no array write; addr_err pulses in this cycle.
- READ:
  - Decrement the latency counter each edge.
  - On the RD_LAT-th edge after acceptance:
    - data_out <= mem[addr], or 0 if addr >= ROWS (addr_err pulses).
    - data_valid=1 for one cycle.
    - Load the PISO with the same word -> SHIFT_OUT.
- SHIFT_OUT:
  - serial_out = PISO MSB; serial_out_valid=1 for exactly COLS consecutive cycles; shift left each edge.
  - serial_in_valid is ignored.
  - After COLS cycles -> IDLE; serial_out returns to 0.
- Write timing: handshake at edge E0 with continuous serial_in_valid:
  - bits sampled at E1..E_COLS;
  - array written at E_COLS+1;
  - cmd_ready high after E_COLS+1.
- Read timing: handshake at E0:
  - data_valid high after E_RD_LAT;
  - cmd_ready high after E_RD_LAT+COLS.
- Extra serial_in bits are ignored. A write command with no serial bits stays in SHIFT_IN until reset.
- Read-after-write to the same row on the next accepted command returns the new data.

Optional Feature:
Macro SRAM_PARITY_EN.
- Defined:
  - Each row stores an extra even-parity bit, computed from sreg in WRITE.
  - On read, stored parity is checked against the read word. On mismatch, a one-cycle output par_err pulses with data_valid.
  - Data is still returned.
  - Out-of-range reads do not raise par_err.
- Not defined:
  - No parity storage or check.
  - par_err port is absent.

Test Plan:
- Write addr 3, bits 1,0,1,0,0,1,0,1 (0xA5), then read addr 3 (COLS=8, RD_LAT=1) -> data_valid one cycle after acceptance, data_out=0xA5; serial_out_valid high 8 cycles with bits 1,0,1,0,0,1,0,1; cmd_ready low for 9 cycles.
- Write 0x3C to addr 0 with serial_in_valid toggling 1,0,1,0… -> WRITE entered only after 8 valid bits; read addr 0 returns 0x3C.
- ROWS=12: write 0xFF to addr 13 -> addr_err pulse in WRITE, array unchanged; read addr 13 -> data_out=0x00, addr_err with data_valid.
- Preload addr 5 = 0x11; start write 0xEE to addr 5; assert arst_n=0 after 4 bits -> IDLE, outputs 0, cmd_ready=1; read addr 5 returns 0x11.
- cmd_valid held high continuously during a read (RD_LAT=3) -> second command accepted only after the 8-cycle SHIFT_OUT; data_valid exactly 3 cycles after each acceptance.
- SRAM_PARITY_EN: write 0x01 to addr 2; force-flip stored bit 0 by backdoor; read addr 2 -> data_out=0x00, par_err=1 coincident with data_valid.

Source files
------------

// File: rtl/sram_serial_port_if.sv
// rtl/sram_serial_port_if.sv - command, serial write and readback signals of sram_serial_port
// Optional par_err signal present when SRAM_PARITY_EN is defined.
interface sram_serial_port_if #(
  parameter int COLS = 8,
  parameter int ROWS = 16
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic            serial_in;
  logic            serial_in_valid;
  logic            data_valid;
  logic [COLS-1:0] data_out;
  logic            serial_out;
  logic            serial_out_valid;
  logic            addr_err;
  logic            busy;

`ifdef SRAM_PARITY_EN
  logic            par_err;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, serial_in, serial_in_valid,
    input  cmd_ready, data_valid, data_out, serial_out, serial_out_valid,
           addr_err, busy, par_err
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, serial_in, serial_in_valid,
    output cmd_ready, data_valid, data_out, serial_out, serial_out_valid,
           addr_err, busy, par_err
  );
`else
  modport master (
    output cmd_valid, cmd_we, cmd_addr, serial_in, serial_in_valid,
    input  cmd_ready, data_valid, data_out, serial_out, serial_out_valid,
           addr_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, serial_in, serial_in_valid,
    output cmd_ready, data_valid, data_out, serial_out, serial_out_valid,
           addr_err, busy
  );
`endif
endinterface

// File: rtl/sram_serial_port.sv
// rtl/sram_serial_port.sv - serial-write, parallel+serial-read SRAM row port with one command handshake
// Row even-parity storage and check enabled by SRAM_PARITY_EN.
module sram_serial_port #(
  parameter int COLS   = 8,
  parameter int ROWS   = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  sram_serial_port_if.slave bus
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(COLS);
`ifdef SRAM_PARITY_EN
  localparam int MW = COLS + 1;
`else
  localparam int MW = COLS;
`endif
  localparam logic [AW:0]   ROWS_W   = (AW+1)'(ROWS);
  localparam logic [CW-1:0] LAST_BIT = CW'(COLS - 1);
  localparam logic [2:0]    LAT_INIT = 3'(RD_LAT);

  typedef enum logic [2:0] {IDLE, SHIFT_IN, WRITE, READ, SHIFT_OUT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [COLS-1:0] sreg_q, sreg_d;
  logic [COLS-1:0] piso_q, piso_d;
  logic [COLS-1:0] dout_q, dout_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      lat_q, lat_d;
  logic            dv_q, dv_d;
  logic            rd_err_q, rd_err_d;
  logic            mem_we;
  logic            in_range;
  logic [MW-1:0]   mem_q [ROWS];
  logic [MW-1:0]   rd_row;
  logic [MW-1:0]   wr_row;
  logic [COLS-1:0] rd_word;
`ifdef SRAM_PARITY_EN
  logic            par_q, par_d;
`endif

  // Addresses are AW bits wide but ROWS need not be a power of two.
  assign in_range = ({1'b0, addr_q} < ROWS_W);
  assign rd_row   = mem_q[addr_q];
  assign rd_word  = rd_row[COLS-1:0];
`ifdef SRAM_PARITY_EN
  assign wr_row   = {^sreg_q, sreg_q};
`else
  assign wr_row   = sreg_q;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sreg_d   = sreg_q;
    piso_d   = piso_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    dv_d     = 1'b0;
    rd_err_d = 1'b0;
    mem_we   = 1'b0;
`ifdef SRAM_PARITY_EN
    par_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d = bus.cmd_addr;
          cnt_d  = '0;
          if (bus.cmd_we) begin
            state_d = SHIFT_IN;
          end else begin
            state_d = READ;
            lat_d   = LAT_INIT;
          end
        end
      end
      SHIFT_IN: begin
        if (bus.serial_in_valid) begin
          sreg_d = {sreg_q[COLS-2:0], bus.serial_in};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) state_d = WRITE;
        end
      end
      WRITE: begin
        // A reset landing on the commit cycle must not leave a row half-updated.
        mem_we  = in_range && arst_n;
        state_d = IDLE;
      end
      READ: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          dout_d   = in_range ? rd_word : '0;
          piso_d   = in_range ? rd_word : '0;
          dv_d     = 1'b1;
          rd_err_d = !in_range;
`ifdef SRAM_PARITY_EN
          par_d    = in_range && ((^rd_word) != rd_row[COLS]);
`endif
          cnt_d    = '0;
          state_d  = SHIFT_OUT;
        end
      end
      SHIFT_OUT: begin
        piso_d = {piso_q[COLS-2:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      sreg_q   <= '0;
      piso_q   <= '0;
      dout_q   <= '0;
      cnt_q    <= '0;
      lat_q    <= '0;
      dv_q     <= 1'b0;
      rd_err_q <= 1'b0;
`ifdef SRAM_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sreg_q   <= sreg_d;
      piso_q   <= piso_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      dv_q     <= dv_d;
      rd_err_q <= rd_err_d;
`ifdef SRAM_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Row array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= wr_row;
  end

  assign bus.cmd_ready        = (state_q == IDLE);
  assign bus.busy             = (state_q != IDLE);
  assign bus.data_valid       = dv_q;
  assign bus.data_out         = dout_q;
  assign bus.serial_out_valid = (state_q == SHIFT_OUT);
  assign bus.serial_out       = (state_q == SHIFT_OUT) && piso_q[COLS-1];
  assign bus.addr_err         = ((state_q == WRITE) && !in_range) || rd_err_q;
`ifdef SRAM_PARITY_EN
  assign bus.par_err          = par_q;
`endif
endmodule

// File: tb/tb_sram_serial_port.sv
// tb/tb_sram_serial_port.sv - directed bench for sram_serial_port (ROWS=12; RD_LAT=1 and RD_LAT=3 instances)
// Parity case included when SRAM_PARITY_EN is defined.
module tb_sram_serial_port;
  localparam int COLS = 8;
  localparam int ROWS = 12;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_we = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic       serial_in = 1'b0;
  logic       serial_in_valid = 1'b0;
  int         errors = 0;
  int         checks = 0;
  int         sel = 0;

  always #5 clk = ~clk;

  sram_serial_port_if #(.COLS(COLS), .ROWS(ROWS)) ifa ();
  sram_serial_port_if #(.COLS(COLS), .ROWS(ROWS)) ifb ();

  assign ifa.cmd_valid = cmd_valid;       assign ifb.cmd_valid = cmd_valid;
  assign ifa.cmd_we = cmd_we;             assign ifb.cmd_we = cmd_we;
  assign ifa.cmd_addr = cmd_addr;         assign ifb.cmd_addr = cmd_addr;
  assign ifa.serial_in = serial_in;       assign ifb.serial_in = serial_in;
  assign ifa.serial_in_valid = serial_in_valid;
  assign ifb.serial_in_valid = serial_in_valid;

  sram_serial_port #(.COLS(COLS), .ROWS(ROWS), .RD_LAT(1)) dut_a (.clk(clk), .arst_n(arst_n), .bus(ifa));
  sram_serial_port #(.COLS(COLS), .ROWS(ROWS), .RD_LAT(3)) dut_b (.clk(clk), .arst_n(arst_n), .bus(ifb));

  logic       o_rdy, o_busy, o_dv, o_sov, o_so, o_aerr;
  logic [7:0] o_dout;
`ifdef SRAM_PARITY_EN
  logic       o_par;
  logic       exp_par = 1'b0;
`endif

  always_comb begin
    if (sel == 0) begin
      o_rdy = ifa.cmd_ready; o_busy = ifa.busy; o_dv = ifa.data_valid; o_dout = ifa.data_out;
      o_sov = ifa.serial_out_valid; o_so = ifa.serial_out; o_aerr = ifa.addr_err;
    end else begin
      o_rdy = ifb.cmd_ready; o_busy = ifb.busy; o_dv = ifb.data_valid; o_dout = ifb.data_out;
      o_sov = ifb.serial_out_valid; o_so = ifb.serial_out; o_aerr = ifb.addr_err;
    end
`ifdef SRAM_PARITY_EN
    o_par = (sel == 0) ? ifa.par_err : ifb.par_err;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    arst_n = 1'b0; cmd_valid = 1'b0; serial_in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  // Starts and ends on a falling edge with the selected port idle.
  task automatic wr(input string tag, input logic [3:0] a, input logic [7:0] w, input bit gaps,
                    input logic exp_aerr);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = a;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      serial_in = w[i]; serial_in_valid = 1'b1;
      @(negedge clk);
      if (gaps && i > 0) begin
        serial_in_valid = 1'b0; serial_in = ~w[i];
        @(negedge clk);
        check($sformatf("%s.gap_busy%0d", tag, i), o_rdy, 1'b0);
      end
    end
    serial_in_valid = 1'b0;
    check({tag, ".write_rdy"}, o_rdy, 1'b0);
    check({tag, ".write_aerr"}, o_aerr, exp_aerr);
    @(negedge clk);
    check({tag, ".idle_rdy"}, o_rdy, 1'b1);
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp,
                    input logic exp_aerr, input int lat);
    int         lowcnt = 0, dv_at = -1, dvcnt = 0, aerrcnt = 0, nbits = 0;
    logic [7:0] dout = '0, sbits = '0;
    logic       aerr_dv = 1'b0;
`ifdef SRAM_PARITY_EN
    logic       par_dv = 1'b0;
`endif
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = a;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (o_rdy) break;
      lowcnt++;
      if (o_dv) begin
        dvcnt++; dv_at = c; dout = o_dout; aerr_dv = o_aerr;
`ifdef SRAM_PARITY_EN
        par_dv = o_par;
`endif
      end
      if (o_aerr) aerrcnt++;
      if (o_sov) begin nbits++; sbits = {sbits[6:0], o_so}; end
      @(negedge clk);
    end
    check({tag, ".dv_at"}, dv_at, lat);
    check({tag, ".dv_cnt"}, dvcnt, 1);
    check({tag, ".data"}, dout, exp);
    check({tag, ".aerr_dv"}, aerr_dv, exp_aerr);
    check({tag, ".aerr_cnt"}, aerrcnt, {31'd0, exp_aerr});
    check({tag, ".nbits"}, nbits, 8);
    check({tag, ".serial"}, sbits, exp);
    check({tag, ".busy_cycles"}, lowcnt, lat + COLS);
    check({tag, ".so_idle"}, o_so, 1'b0);
    check({tag, ".data_held"}, o_dout, exp);
`ifdef SRAM_PARITY_EN
    check({tag, ".par"}, par_dv, exp_par);
`endif
  endtask

  initial begin
    int dv1, dv2, rdy_first, nrdy;
    logic [7:0] d2;

    do_reset();
    check("rst.rdy", o_rdy, 1'b1);
    check("rst.busy", o_busy, 1'b0);
    check("rst.dv", o_dv, 1'b0);
    check("rst.dout", o_dout, 8'h00);
    check("rst.sov", o_sov, 1'b0);
    check("rst.so", o_so, 1'b0);
    check("rst.aerr", o_aerr, 1'b0);
    check("rst.b_rdy", ifb.cmd_ready, 1'b1);

    wr("t1w", 4'd3, 8'hA5, 1'b0, 1'b0);
    rd("t1r", 4'd3, 8'hA5, 1'b0, 1);

    wr("t2w", 4'd0, 8'h3C, 1'b1, 1'b0);
    rd("t2r", 4'd0, 8'h3C, 1'b0, 1);

    wr("last_w", 4'd11, 8'h96, 1'b0, 1'b0);
    rd("last_r", 4'd11, 8'h96, 1'b0, 1);

    wr("oor_w", 4'd13, 8'hFF, 1'b0, 1'b1);
    rd("oor_r13", 4'd13, 8'h00, 1'b1, 1);
    rd("oor_r12", 4'd12, 8'h00, 1'b1, 1);
    rd("keep3", 4'd3, 8'hA5, 1'b0, 1);
    rd("keep11", 4'd11, 8'h96, 1'b0, 1);

    wr("t4pre", 4'd5, 8'h11, 1'b0, 1'b0);
    rd("t4pre_r", 4'd5, 8'h11, 1'b0, 1);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'd5;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = 1'b0;
    for (int i = 7; i >= 4; i--) begin
      serial_in = 1'b1 ^ (i == 4); serial_in_valid = 1'b1;
      @(negedge clk);
    end
    check("t4.mid_busy", o_busy, 1'b1);
    arst_n = 1'b0; serial_in_valid = 1'b0;
    @(negedge clk);
    check("t4.rst_rdy", o_rdy, 1'b1);
    check("t4.rst_busy", o_busy, 1'b0);
    check("t4.rst_dout", o_dout, 8'h00);
    check("t4.rst_sov", o_sov, 1'b0);
    arst_n = 1'b1;
    @(negedge clk);
    rd("t4r", 4'd5, 8'h11, 1'b0, 1);

    sel = 1;
    do_reset();
    wr("t5w", 4'd1, 8'h5A, 1'b0, 1'b0);
    dv1 = -1; dv2 = -1; rdy_first = -1; nrdy = 0; d2 = '0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'd1;
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      if (o_dv) begin
        if (dv1 < 0) dv1 = c;
        else if (dv2 < 0) begin dv2 = c; d2 = o_dout; end
      end
      if (o_rdy) begin
        nrdy++;
        if (rdy_first < 0) rdy_first = c;
      end
      if (c == 12) cmd_valid = 1'b0;
      if (c > 12 && o_rdy) break;
      @(negedge clk);
    end
    check("t5.dv1", dv1, 3);
    check("t5.rdy_first", rdy_first, 11);
    check("t5.dv2", dv2, 15);
    check("t5.rdy_samples", nrdy, 2);
    check("t5.data2", d2, 8'h5A);

`ifdef SRAM_PARITY_EN
    sel = 0;
    do_reset();
    wr("par_w", 4'd2, 8'h01, 1'b0, 1'b0);
    dut_a.mem_q[2][0] = ~dut_a.mem_q[2][0];
    exp_par = 1'b1;
    rd("par_r", 4'd2, 8'h00, 1'b0, 1);
    exp_par = 1'b0;
    rd("par_ok", 4'd3, 8'hA5, 1'b0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
